// File: rtl/sha1_msg_sched.sv
// SHA-1 message schedule: loads 16 message words into a circular buffer, then
// streams W_0..W_{ROUNDS-1} with valid/ready handshakes on both sides.
module sha1_msg_sched #(
   parameter int unsigned ROUNDS = 80
) (
   input  logic        clk,
   input  logic        r_n,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [6:0]  out_idx,
   output logic        out_last
);

   localparam int unsigned WW    = 32;
   localparam int unsigned IW    = 7;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   typedef enum logic {LOAD, EXPAND} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   load_cnt_q, load_cnt_d;
   logic [IW-1:0]   t_q, t_d;
   logic [WW-1:0]   mem_q [DEPTH];

   logic            wr_en;
   logic [AW-1:0]   wr_idx;
   logic [WW-1:0]   wr_data;

   logic [AW-1:0]   t_lo, idx3, idx8, idx14;
   logic [WW-1:0]   mix, expand_word;
   logic            is_expand, is_last, in_fire;

   // Tap indices wrap in 4 bits; (t-16)%16 is simply t%16.
   assign t_lo        = t_q[AW-1:0];
   assign idx3        = AW'(t_lo - AW'(3));
   assign idx8        = AW'(t_lo - AW'(8));
   assign idx14       = AW'(t_lo - AW'(14));
   assign mix         = mem_q[idx3] ^ mem_q[idx8] ^ mem_q[idx14] ^ mem_q[t_lo];
   assign expand_word = {mix[WW-2:0], mix[WW-1]};
   assign is_expand   = (t_q >= IW'(DEPTH));
   assign is_last     = (t_q == IW'(ROUNDS - 1));

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == EXPAND);
   assign out_idx   = t_q;
   assign out_word  = is_expand ? expand_word : mem_q[t_lo];
   assign out_last  = out_valid & is_last;
   assign in_fire   = in_valid & in_ready;

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      t_d        = t_q;
      wr_en      = 1'b0;
      wr_idx     = load_cnt_q;
      wr_data    = in_word;
      if (clr) begin
         state_d    = LOAD;
         load_cnt_d = '0;
         t_d        = '0;
      end else if (state_q == LOAD) begin
         if (in_fire) begin
            wr_en      = 1'b1;
            load_cnt_d = AW'(load_cnt_q + AW'(1));
            if (load_cnt_q == AW'(DEPTH - 1)) begin
               state_d    = EXPAND;
               load_cnt_d = '0;
               t_d        = '0;
            end
         end
      end else begin
         if (out_ready) begin
            t_d = IW'(t_q + IW'(1));
            // Expanded words overwrite the oldest slot, which is no longer needed.
            if (is_expand) begin
               wr_en   = 1'b1;
               wr_idx  = t_lo;
               wr_data = expand_word;
            end
            if (is_last) begin
               state_d = LOAD;
               t_d     = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         state_q    <= LOAD;
         load_cnt_q <= '0;
         t_q        <= '0;
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         t_q        <= t_d;
      end
   end

   // Buffer carries no reset; its contents only matter after a full load.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_sha1_msg_sched.sv
// Directed bench for sha1_msg_sched: "abc" schedule, stalls, back-to-back
// blocks, clr abort, async reset, and a ROUNDS=16 build.
module tb_sha1_msg_sched;

   logic        clk = 1'b0;
   logic        r_n, clr;
   logic        in_valid, in_ready, out_valid, out_ready, out_last;
   logic [31:0] in_word, out_word;
   logic [6:0]  out_idx;

   logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_last_s;
   logic [31:0] in_word_s, out_word_s;
   logic [6:0]  out_idx_s;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m  [16];
   logic [31:0] mb [16];
   logic [31:0] w  [128];

   always #5 clk = ~clk;

   sha1_msg_sched #(.ROUNDS(80)) dut (
      .clk(clk), .r_n(r_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_idx(out_idx), .out_last(out_last)
   );

   sha1_msg_sched #(.ROUNDS(16)) dut16 (
      .clk(clk), .r_n(r_n), .clr(clr),
      .in_valid(in_valid_s), .in_ready(in_ready_s), .in_word(in_word_s),
      .out_valid(out_valid_s), .out_ready(out_ready_s), .out_word(out_word_s),
      .out_idx(out_idx_s), .out_last(out_last_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Straightforward array-form SHA-1 expansion as the reference.
   function automatic void build_ref();
      logic [31:0] x;
      for (int i = 0; i < 16; i++) w[i] = m[i];
      for (int i = 16; i < 128; i++) begin
         x    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
         w[i] = {x[30:0], x[31]};
      end
   endfunction

   task automatic load_blk();
      for (int j = 0; j < 16; j++) begin
         in_valid = 1'b1;
         in_word  = m[j];
         chk("load_ready", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_sched(input int n);
      out_ready = 1'b1;
      for (int t = 0; t < n; t++) begin
         chk("w_valid", out_valid, 1);
         chk("w_idx", out_idx, 32'(t));
         chk("w_word", out_word, w[t]);
         chk("w_last", out_last, (t == 79) ? 1 : 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
   endtask

   task automatic set_abc();
      for (int j = 0; j < 16; j++) m[j] = 32'h0;
      m[0]  = 32'h61626380;
      m[15] = 32'h00000018;
      build_ref();
   endtask

   task automatic set_rand();
      for (int j = 0; j < 16; j++) m[j] = $urandom;
      build_ref();
   endtask

   initial begin
      int et, cyc, low, r;
      r_n = 1'b0; clr = 1'b0;
      in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
      in_valid_s = 1'b0; in_word_s = '0; out_ready_s = 1'b0;
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      @(posedge clk); #1;
      r_n = 1'b1;

      // "abc" block, free-running output
      set_abc();
      load_blk();
      chk("abc_latency_valid", out_valid, 1);
      chk("abc_w0", out_word, 32'h61626380);
      run_sched(16);
      chk("abc_w16", out_word, 32'hC2C4C700);
      out_ready = 1'b1; @(posedge clk); #1;
      chk("abc_w17", out_word, 32'h00000000);
      @(posedge clk); #1;
      chk("abc_w18", out_word, 32'h00000030);
      out_ready = 1'b0;
      for (int t = 18; t < 80; t++) begin
         chk("abc_idx", out_idx, 32'(t));
         chk("abc_word", out_word, w[t]);
         chk("abc_last", out_last, (t == 79) ? 1 : 0);
         out_ready = 1'b1;
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      chk("abc_back_ready", in_ready, 1);
      chk("abc_back_valid", out_valid, 0);

      // Same block with random output stalls
      load_blk();
      et = 0; cyc = 0;
      while (et < 80 && cyc < 2000) begin
         chk("stall_word", out_word, w[et]);
         chk("stall_idx", out_idx, 32'(et));
         r = $urandom_range(0, 1);
         out_ready = r[0];
         @(posedge clk); #1;
         if (r[0]) et++;
         cyc++;
      end
      out_ready = 1'b0;
      chk("stall_count", 32'(et), 80);
      chk("stall_back_ready", in_ready, 1);

      // Two blocks back-to-back with in_valid held high
      set_abc();
      for (int j = 0; j < 16; j++) mb[j] = 32'h12345678 + 32'(j) * 32'h01010101;
      in_valid = 1'b1;
      for (int j = 0; j < 16; j++) begin
         in_word = m[j];
         @(posedge clk); #1;
      end
      in_word = mb[0]; out_ready = 1'b1; low = 0;
      while (!in_ready && low < 200) begin
         @(posedge clk); #1;
         low++;
      end
      chk("b2b_busy_cycles", 32'(low), 80);
      for (int j = 0; j < 16; j++) begin
         in_word = mb[j];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("b2b_w0", out_word, mb[0]);
      m = mb; build_ref();
      run_sched(80);

      // clr at t = 40 with out_ready high
      set_rand();
      load_blk();
      run_sched(40);
      chk("clr_pre_idx", out_idx, 40);
      clr = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; out_ready = 1'b0;
      chk("clr_in_ready", in_ready, 1);
      chk("clr_out_valid", out_valid, 0);
      chk("clr_idx", out_idx, 0);
      set_rand();
      load_blk();
      run_sched(80);

      // Async reset mid-LOAD (load_cnt = 7)
      set_rand();
      for (int j = 0; j < 7; j++) begin
         in_valid = 1'b1; in_word = m[j];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #4 r_n = 1'b0;
      #1;
      chk("rstl_in_ready", in_ready, 1);
      chk("rstl_out_valid", out_valid, 0);
      @(posedge clk); #1;
      r_n = 1'b1;
      set_rand();
      load_blk();
      chk("rstl_w0", out_word, m[0]);
      run_sched(80);

      // Async reset mid-EXPAND
      set_rand();
      load_blk();
      run_sched(5);
      #4 r_n = 1'b0;
      #1;
      chk("rste_out_valid", out_valid, 0);
      chk("rste_in_ready", in_ready, 1);
      chk("rste_idx", out_idx, 0);
      @(posedge clk); #1;
      r_n = 1'b1;
      set_rand();
      load_blk();
      run_sched(80);

      // ROUNDS = 16 build
      set_rand();
      for (int j = 0; j < 16; j++) begin
         in_valid_s = 1'b1; in_word_s = m[j];
         @(posedge clk); #1;
      end
      in_valid_s = 1'b0; out_ready_s = 1'b1;
      for (int t = 0; t < 16; t++) begin
         chk("r16_valid", out_valid_s, 1);
         chk("r16_idx", out_idx_s, 32'(t));
         chk("r16_word", out_word_s, m[t]);
         chk("r16_last", out_last_s, (t == 15) ? 1 : 0);
         @(posedge clk); #1;
      end
      out_ready_s = 1'b0;
      chk("r16_back_ready", in_ready_s, 1);
      chk("r16_back_valid", out_valid_s, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sha1_msg_sched.md
SHA1_MSG_SCHED -- requirements
Module: sha1_msg_sched

Interface
REQ-001 The block SHALL have one parameter: ROUNDS, default 80, the number of W_t words emitted per block; legal range 16..128.
REQ-002 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port r_n  input  1  asynchronous active-low reset.
REQ-005 Port clr  input  1  synchronous active-high abort of the current block.
REQ-006 Port in_valid  input  1  in_word is valid.
REQ-007 Port in_ready  output  1  block accepts a message word this cycle.
REQ-008 Port in_word  input  32  message word M_j, big-endian word order, j = 0..15.
REQ-009 Port out_valid  output  1  out_word holds W_t.
REQ-010 Port out_ready  input  1  downstream round stage consumes W_t this cycle.
REQ-011 Port out_word  output  32  schedule word W_t.
REQ-012 Port out_idx  output  7  round index t of out_word.
REQ-013 Port out_last  output  1  high while t = ROUNDS-1 and out_valid is high.

Function
REQ-014 The block SHALL hold a 16 x 32-bit circular buffer, a 4-bit load counter, a 7-bit round counter t, and a two-state FSM {LOAD, EXPAND}.
REQ-015 A transfer SHALL occur on a rising edge where valid and ready are both high; neither side may make valid depend combinationally on ready.
REQ-016 In LOAD: in_ready = 1 and out_valid = 0; each input transfer writes in_word to buffer[load_cnt], then load_cnt increments.
REQ-017 An input transfer with load_cnt = 15 SHALL move the FSM to EXPAND, clear load_cnt to 0 and set t = 0, so out_valid = 1 on the following cycle (1-cycle latency from the last input word to W_0).
REQ-018 In EXPAND: in_ready = 0 and out_valid = 1; out_idx = t.
REQ-019 For t < 16, out_word SHALL equal buffer[t].
REQ-020 For t >= 16, out_word SHALL equal ROTL1(buffer[(t-3)%16] ^ buffer[(t-8)%16] ^ buffer[(t-14)%16] ^ buffer[(t-16)%16]), with all indices taken modulo 16 (4-bit wrap).
REQ-021 On an output transfer with t >= 16, out_word SHALL be written into buffer[t%16].
REQ-022 On an output transfer with t < 16, the buffer SHALL be left unchanged.
REQ-023 On an output transfer, t SHALL increment by 1.
REQ-024 On an output transfer with t = ROUNDS-1, the FSM SHALL return to LOAD and t SHALL clear to 0; in_ready rises on the next cycle.
REQ-025 When out_ready = 0 in EXPAND, out_word, out_idx and all state SHALL hold unchanged for any number of cycles.
REQ-026 The block SHALL apply no backpressure bubbles: consecutive output transfers SHALL be possible on every cycle, and consecutive input transfers SHALL be possible on every cycle.
REQ-027 When clr = 1 at a rising edge, the FSM SHALL go to LOAD and load_cnt and t SHALL clear to 0; clr SHALL take priority over any simultaneous transfer.
REQ-028 clr SHALL leave the buffer contents unchanged.
REQ-029 A new block SHALL NOT begin loading until all ROUNDS words of the current block have been transferred, unless clr is asserted.

Reset
REQ-030 While r_n = 0, the block SHALL asynchronously force FSM = LOAD, load_cnt = 0 and t = 0.
REQ-031 Reset values SHALL be in_ready = 1, out_valid = 0, out_idx = 0 and out_last = 0; out_word is don't-care while out_valid = 0.
REQ-032 The buffer SHALL require no reset.
REQ-033 Deassertion of r_n SHALL be synchronous to clk, and the first transfer SHALL be legal on the first edge after deassertion.
REQ-034 Reset asserted mid-LOAD or mid-EXPAND SHALL discard the partial block.

Verification
REQ-035 Load the padded block for "abc" (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), out_ready = 1 -> W_0 = 0x61626380, W_16 = 0xC2C4C700, W_79 emitted with out_last = 1, and all 80 words match a reference model.
REQ-036 Repeat scenario 1 with out_ready randomly toggled at 50% -> identical W sequence, out_word and out_idx stable during every stall, and no words dropped or duplicated.
REQ-037 Feed two blocks back-to-back with in_valid held high -> in_ready stays low for exactly the 80 EXPAND cycles, and the second block's W_0 equals its M0.
REQ-038 Assert clr at t = 40 together with out_ready = 1 -> no transfer is counted, in_ready = 1 on the next cycle, and a fresh block produces a correct schedule.
REQ-039 Pull r_n low asynchronously mid-cycle during LOAD with load_cnt = 7 -> in_ready = 1 and out_valid = 0 immediately, and the next 16 words form a new block.
REQ-040 Build with ROUNDS = 16 -> out_last is asserted at t = 15, no ROTL words are generated, and the block returns to LOAD.
